// File: rtl/scale_seq.sv
// Sequential shift-add scaler for sign-magnitude words: one mask term per clock into a single accumulator, then saturate.
// Optional build macro SCALE_EARLY_EXIT_EN stops RUN after the highest set mask bit instead of always running WIDTH terms.
module scale_seq #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] DEF_MASK = 32'h9DDA_11C5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outdata,
  output logic             out_sat,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // The upstream side is ready only in IDLE; the downstream side sees valid only in DONE,
  // and outdata/out_sat stay constant for as long as valid is held without ready.

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             sign_q, sign_d;
  logic [WIDTH-2:0] mag_q, mag_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] outdata_q, outdata_d;
  logic             sat_q, sat_d;
  logic             rdy_q;

  logic [WIDTH:0]   term;
  logic [WIDTH:0]   acc_sum;
  logic             last_term;
  logic             sat_now;
  logic [WIDTH-2:0] mag_res;

  // Term 0 is the only left shift; every other term is a truncating right shift.
  always_comb begin
    term = '0;
    if (k_q == '0) begin
      term = {1'b0, mag_q, 1'b0};
    end else begin
      term = {2'b00, mag_q >> k_q};
    end
  end

  assign acc_sum = acc_q + (snap_q[k_q] ? term : '0);

`ifdef SCALE_EARLY_EXIT_EN
  logic [WIDTH-1:0] hi_bits;
  assign hi_bits   = (snap_q >> k_q) >> 1;
  assign last_term = (hi_bits == '0);
`else
  assign last_term = (k_q == KW'(WIDTH - 1));
`endif

  // The accumulator peaks at 3*mag, so only its top two bits can signal overflow.
  assign sat_now = |acc_sum[WIDTH:WIDTH-1];
  assign mag_res = sat_now ? '1 : acc_sum[WIDTH-2:0];

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    snap_d    = snap_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    k_d       = k_q;
    outdata_d = outdata_q;
    sat_d     = sat_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          mask_d = cfg_mask;
        end
        if (in_valid && in_ready) begin
          sign_d  = ina[WIDTH-1];
          mag_d   = ina[WIDTH-2:0];
          snap_d  = mask_q;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        k_d   = k_q + KW'(1);
        if (last_term) begin
          outdata_d = {sign_q, mag_res};
          sat_d     = sat_now;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mask_q    <= DEF_MASK;
      snap_q    <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      outdata_q <= '0;
      sat_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      snap_q    <= snap_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      outdata_q <= outdata_d;
      sat_q     <= sat_d;
      rdy_q     <= 1'b1;
    end
  end

  // rdy_q keeps in_ready low until the first clock after reset release.
  assign in_ready    = (state_q == S_IDLE) && rdy_q;
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_RUN);
  assign outdata     = outdata_q;
  assign out_sat     = sat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scale_seq.sv
// Directed plus randomized bench for scale_seq against an arithmetic reference of the scaling rule.
module tb_scale_seq;

  localparam int          W   = 32;
  localparam logic [31:0] DEF = 32'h9DDA_11C5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  ina = '0;
  logic          cfg_we = 1'b0;
  logic [W-1:0]  cfg_mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  outdata;
  logic          out_sat;
  logic          busy;
  logic [1:0]    dbg_state;

  int            n_vec = 0;
  int            n_err = 0;
  logic [31:0]   mask_m = DEF;
  logic [W-1:0]  exp_q[$];

  scale_seq #(.WIDTH(W), .DEF_MASK(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ina(ina),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .out_valid(out_valid), .out_ready(out_ready),
    .outdata(outdata), .out_sat(out_sat), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: sum of individually truncated shifted magnitudes, then saturate.
  function automatic logic [32:0] ref_scale(input logic [31:0] a, input logic [31:0] m);
    longint unsigned mag;
    longint unsigned sum;
    mag = {33'd0, a[30:0]};
    sum = 0;
    for (int k = 0; k < 32; k++) begin
      if (m[k]) begin
        if (k == 0) sum += mag * 2;
        else        sum += mag / (64'd1 << k);
      end
    end
    if (sum >= 64'h8000_0000) return {1'b1, a[31], 31'h7FFF_FFFF};
    return {1'b0, a[31], sum[30:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] m);
`ifdef SCALE_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int k = 0; k < 32; k++) if (m[k]) h = k;
    return h + 1;
`else
    return (m == m) ? 32 : 32;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    check("wait_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic cfg_write(input logic [31:0] m);
    wait_ready();
    cfg_we   = 1'b1;
    cfg_mask = m;
    tick();
    cfg_we   = 1'b0;
    mask_m   = m;
  endtask

  // One full operation; optional same-cycle cfg write and optional DONE stall with noise on inputs.
  task automatic run_op(input logic [31:0] a, input bit do_cfg, input logic [31:0] cm, input int stall);
    logic [32:0] r;
    int          lat;
    int          exp_lat;
    logic [W-1:0] exp_data;
    wait_ready();
    r       = ref_scale(a, mask_m);
    exp_lat = ref_lat(mask_m);
    exp_q.push_back(r[31:0]);
    in_valid = 1'b1;
    ina      = a;
    if (do_cfg) begin
      cfg_we   = 1'b1;
      cfg_mask = cm;
    end
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (do_cfg) mask_m = cm;
    check("accepted_running", {62'd0, in_ready, busy}, 64'b01);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    exp_data = exp_q.pop_front();
    check("outdata", 64'(outdata), 64'(exp_data));
    check("out_sat", 64'(out_sat), 64'(r[32]));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      ina      = $urandom;
      cfg_we   = 1'b1;
      cfg_mask = $urandom;
      tick();
      check("stall_hold", {29'd0, out_valid, in_ready, busy, outdata}, {29'd0, 3'b100, exp_data});
    end
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] a;

    // reset
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {29'd0, out_valid, out_sat, busy, in_ready, outdata}, 64'd0);
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_low_before_clock", 64'(in_ready), 64'd0);
    tick();
    check("ready_after_clock", 64'(in_ready), 64'd1);

    // directed values with the default mask
    run_op(32'h0000_0100, 1'b0, 32'h0, 0);
    run_op(32'h8000_0100, 1'b0, 32'h0, 0);
    run_op(32'hC000_0000, 1'b0, 32'h0, 0);
    run_op(32'h8000_0000, 1'b0, 32'h0, 0);
    run_op(32'h7FFF_FFFF, 1'b0, 32'h0, 0);

    // same-cycle cfg write and accept: old mask now, new mask next time
    run_op(32'h0000_1234, 1'b1, 32'h0000_0001, 0);
    run_op(32'h0000_1234, 1'b0, 32'h0, 0);

    // backpressure with noise on in_valid/cfg_we, then confirm mask unchanged
    cfg_write(DEF);
    run_op(32'h0000_0100, 1'b0, 32'h0, 5);
    run_op(32'h0000_0100, 1'b0, 32'h0, 0);

    // boundary masks
    cfg_write(32'h0000_0000);
    run_op(32'h7FFF_FFFF, 1'b0, 32'h0, 0);
    cfg_write(32'h8000_0000);
    run_op(32'hFFFF_FFFF, 1'b0, 32'h0, 0);
    cfg_write(32'hFFFF_FFFF);
    run_op(32'h2AAA_AAAA, 1'b0, 32'h0, 1);

    // randomized operands and masks
    for (int i = 0; i < 12; i++) begin
      m = $urandom;
      if (i % 4 == 1) m = m & 32'h0000_00FF;
      a = $urandom;
      if (i % 3 == 0) a = a & 32'h8FFF_FFFF;
      if (i % 2 == 0) begin
        cfg_write(m);
        run_op(a, 1'b0, 32'h0, $urandom_range(0, 3));
      end else begin
        run_op(a, 1'b1, m, $urandom_range(0, 2));
      end
    end

    // reset in the middle of RUN after a non-default mask write
    cfg_write(32'h0000_0001);
    wait_ready();
    in_valid = 1'b1;
    ina      = 32'h0000_0100;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {29'd0, out_valid, out_sat, busy, in_ready, outdata}, 64'd0);
    mask_m = DEF;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_midrun_reset", 64'(in_ready), 64'd1);
    run_op(32'h0000_0100, 1'b0, 32'h0, 0);
    run_op(32'h8000_0100, 1'b0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
